// File: rtl/axis_timing_scheduler.sv
// axis_timing_scheduler: launches the four axis timing calculators, collects their results and hands the slowest axis to the executor.
// Optional CALC watchdog enabled by defining AXIS_TIMEOUT_EN.
module axis_timing_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [3:0]  axis_enable_i,
    output logic [3:0]  calc_start_o,
    input  logic [3:0]  calc_done_i,
    input  logic [31:0] params_a_i [0:4],
    input  logic [31:0] params_b_i [0:4],
    input  logic [31:0] params_z_i [0:4],
    input  logic [31:0] params_e_i [0:4],
    input  logic [63:0] timing_a_i [0:3],
    input  logic [63:0] timing_b_i [0:3],
    input  logic [63:0] timing_z_i [0:3],
    input  logic [63:0] timing_e_i [0:3],
    output logic        busy_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [1:0]  max_axis_o,
    output logic [63:0] max_timing_o [0:3],
    output logic [31:0] max_params_o [0:4],
    output logic        timeout_o
);
    typedef enum logic [2:0] {IDLE, CALC, SCAN, OUT, ERR} state_e;
    state_e      state_q, state_d;
    logic [3:0]  en_q, en_d, done_q, done_d, acc;
    logic        first_q, first_d, have_q, have_d, take, load_max, zero_max;
    logic [1:0]  idx_q, idx_d, best_q, best_d, max_axis_q;
    logic [31:0] par_in [0:3][0:4];
    logic [63:0] tim_in [0:3][0:3];
    logic [31:0] par_q [0:3][0:4];
    logic [63:0] tim_q [0:3][0:3];
    logic [63:0] max_timing_q [0:3];
    logic [31:0] max_params_q [0:4];
`ifdef AXIS_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
`endif
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            par_in[0][k] = params_a_i[k];
            par_in[1][k] = params_b_i[k];
            par_in[2][k] = params_z_i[k];
            par_in[3][k] = params_e_i[k];
        end
        for (int k = 0; k < 4; k++) begin
            tim_in[0][k] = timing_a_i[k];
            tim_in[1][k] = timing_b_i[k];
            tim_in[2][k] = timing_z_i[k];
            tim_in[3][k] = timing_e_i[k];
        end
    end
    // Only the first done of an enabled axis, after the launch cycle, is captured.
    assign acc = (state_q == CALC && !first_q) ? (calc_done_i & en_q & ~done_q) : 4'b0;
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        done_d   = done_q | acc;
        first_d  = 1'b0;
        idx_d    = idx_q;
        best_d   = best_q;
        have_d   = have_q;
        take     = 1'b0;
        load_max = 1'b0;
        zero_max = 1'b0;
`ifdef AXIS_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE, ERR: if (start_i) begin
                en_d   = axis_enable_i;
                done_d = 4'b0;
`ifdef AXIS_TIMEOUT_EN
                cnt_d     = '0;
                timeout_d = 1'b0;
`endif
                if (axis_enable_i == 4'b0) begin
                    state_d  = OUT;
                    zero_max = 1'b1;
                end else begin
                    state_d = CALC;
                    first_d = 1'b1;
                end
            end
            CALC: if (done_d == en_q) begin
                state_d = SCAN;
                idx_d   = 2'd0;
                have_d  = 1'b0;
            end else begin
`ifdef AXIS_TIMEOUT_EN
                if (cnt_q == TIMEOUT_CYCLES) begin
                    state_d   = ERR;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            SCAN: begin
                // Strictly-greater replacement keeps ties on the lower index.
                take   = en_q[idx_q] && (!have_q || tim_q[idx_q][3] > tim_q[best_q][3]);
                best_d = take ? idx_q : best_q;
                have_d = have_q | en_q[idx_q];
                idx_d  = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d  = OUT;
                    load_max = 1'b1;
                end
            end
            OUT: if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            en_q         <= '0;
            done_q       <= '0;
            first_q      <= 1'b0;
            idx_q        <= '0;
            best_q       <= '0;
            have_q       <= 1'b0;
            max_axis_q   <= '0;
            max_timing_q <= '{default: '0};
            max_params_q <= '{default: '0};
            par_q        <= '{default: '{default: '0}};
            tim_q        <= '{default: '{default: '0}};
`ifdef AXIS_TIMEOUT_EN
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            done_q  <= done_d;
            first_q <= first_d;
            idx_q   <= idx_d;
            best_q  <= best_d;
            have_q  <= have_d;
`ifdef AXIS_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    par_q[i] <= par_in[i];
                    tim_q[i] <= tim_in[i];
                end
            end
            if (zero_max) begin
                max_axis_q   <= '0;
                max_timing_q <= '{default: '0};
                max_params_q <= '{default: '0};
            end else if (load_max) begin
                max_axis_q   <= best_d;
                max_timing_q <= tim_q[best_d];
                max_params_q <= par_q[best_d];
            end
        end
    end
    assign calc_start_o = (state_q == CALC && first_q) ? en_q : 4'b0;
    assign busy_o       = state_q != IDLE && state_q != ERR;
    assign out_valid_o  = state_q == OUT;
    assign max_axis_o   = max_axis_q;
    assign max_timing_o = max_timing_q;
    assign max_params_o = max_params_q;
`ifdef AXIS_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif
endmodule

// File: doc/axis_timing_scheduler.md
# axis_timing_scheduler

Sequences one motion segment through the four per-axis speed/jerk/acc timing calculators (axes A, B, Z, E). It launches the calculators, collects their results as they finish in any order, scans them serially to pick the axis with the longest total move time, and presents that axis's timing profile and parameters to the segment executor over a valid/ready handshake. It sits between the G-code segment loader and the step generators.

## Interface
- TIMEOUT_CYCLES, 65535: CALC-state watchdog limit, in clk cycles (used only with AXIS_TIMEOUT_EN)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state clears while low
- start  in  1  one-cycle request to begin a segment; honoured only in IDLE (and ERR)
- axis_enable  in  4  axes moving this segment; bit0=A, 1=B, 2=Z, 3=E; sampled on accepted start
- calc_start  out  4  one-cycle launch pulse per enabled axis calculator
- calc_done  in  4  per-axis completion pulse
- params_a/b/z/e  in  32 x [0:4]  per-axis params; captured on that axis's accepted calc_done
- timing_a/b/z/e  in  64 x [0:3]  per-axis phase timings; element [3] is total time; captured with params
- busy  out  1  high in every state except IDLE and ERR
- out_valid  out  1  result available
- out_ready  in  1  executor accepts result
- max_axis  out  2  index of the selected axis
- max_timing  out  64 x [0:3]  timing of the selected axis
- max_params  out  32 x [0:4]  params of the selected axis
- timeout  out  1  watchdog fired; constant 0 without AXIS_TIMEOUT_EN

## Operation
- States: IDLE, CALC, SCAN, OUT, ERR (ERR exists only with AXIS_TIMEOUT_EN).
- IDLE: on start, latch axis_enable, clear done mask, go to CALC. If axis_enable==0, go directly to OUT with max_axis=0 and all timing/params zero.
- CALC: calc_start = enable mask in the first CALC cycle only. calc_done is accepted from the second CALC cycle onward. Each accepted bit for an enabled axis sets a sticky done bit and captures that axis's params/timing. Done for disabled axes, repeated done bits, or done outside CALC is ignored; a repeated done does not recapture. When done mask == enable mask, go to SCAN.
- SCAN: exactly 4 cycles, index 0..3, one axis per cycle. Disabled axes are skipped.
  - The first enabled axis is taken unconditionally.
  - A later enabled axis replaces the current best only if its timing[3] is strictly greater (unsigned 64-bit). Ties go to the lower index.
  - Then go to OUT.
- OUT: out_valid=1. max_* are registered and stay stable until out_valid && out_ready, then return to IDLE. A start in the transfer cycle is ignored.
- Reset value of every output is 0. Reset mid-operation aborts immediately; calc_start drops asynchronously.

## Timing
- Accepted start at cycle 0: CALC entered at cycle 1, calc_start high at cycle 1 only.
- Last required calc_done at cycle D: SCAN at D+1..D+4, out_valid at D+5.
- Zero-axis segment: out_valid at cycle 1.
- Transfer at cycle T: busy low and IDLE at T+1; the earliest new start is accepted at T+1.
- Throughput: one segment in flight; calculators are never relaunched before the result transfers.

## Configuration
- AXIS_TIMEOUT_EN defined:
  - A 32-bit counter runs in CALC; it clears on CALC entry.
  - When the counter reaches TIMEOUT_CYCLES with done bits still missing, go to ERR, set timeout=1 and drop busy. out_valid is never raised.
  - ERR behaves as IDLE for start; an accepted start clears timeout.
- AXIS_TIMEOUT_EN undefined: no counter and no ERR state; CALC waits indefinitely; timeout is tied 0.

## Test plan
- Enable=4'b1111, done order E,A,Z,B at cycles 3,5,6,9; timing[3] = 100,400,250,90 -> calc_start=4'b1111 at cycle 1 only, out_valid at 14, max_axis=1, max_timing/params equal B's captured values.
- Tie: enable=4'b1111, all timing[3]=500 -> max_axis=0. With enable=4'b1100 and Z=E=500 -> max_axis=2.
- Enable=4'b0000 -> out_valid at cycle 1 with max_axis=0 and all outputs zero; hold out_ready low 10 cycles -> outputs stable, then single transfer, busy low next cycle.
- Inputs change after capture, spurious done on a disabled axis, duplicate done on an enabled axis -> results reflect the first captured values; done mask unaffected.
- Reset driven low mid-CALC and mid-OUT -> all outputs 0 immediately; a fresh start afterwards completes normally.
- With AXIS_TIMEOUT_EN and TIMEOUT_CYCLES=20, axis Z never done -> timeout=1, busy=0, out_valid=0; next start clears timeout and a normal run passes.
